// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   state_e      - sequencer states (IDLE, XFER, DONE)
//   BEATS        - byte beats per 32-bit word access
//   REQ_CPU/DBG  - requester identifiers used for gnt_id
//   req_data_t   - latched per-access payload (direction + write word)
//   word_byte()  - extract big-endian byte lane b from a word
//   put_byte()   - replace big-endian byte lane b of a word
package dmem_arb_pkg;

  localparam int unsigned BEATS  = 4;
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] wdata;
  } req_data_t;

  // Lane 0 is the most significant byte.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [BEAT_W-1:0] b);
    logic [BYTE_W-1:0] r;
    case (b)
      2'd0:    r = w[31:24];
      2'd1:    r = w[23:16];
      2'd2:    r = w[15:8];
      default: r = w[7:0];
    endcase
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] w,
                                                 input logic [BEAT_W-1:0] b,
                                                 input logic [BYTE_W-1:0] d);
    logic [WORD_W-1:0] r;
    r = w;
    case (b)
      2'd0:    r[31:24] = d;
      2'd1:    r[23:16] = d;
      2'd2:    r[15:8]  = d;
      default: r[7:0]   = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr: two-way round-robin picker with a registered pointer.
//   clk, rst_n - clock, async active-low reset
//   req0, req1 - current requests
//   gnt_en     - a grant is taken this cycle; pointer moves to the loser
//   winner_c   - combinational pick (sole requester, else the pointer)
//   ptr        - registered round-robin pointer (resets to requester 0)
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic gnt_en,
  output logic winner_c,
  output logic ptr
);

  logic ptr_q, ptr_d;

  // Pick: a lone requester wins outright; a tie goes to the pointer.
  always_comb begin
    winner_c = ptr_q;
    if (req0 && !req1) begin
      winner_c = REQ_CPU;
    end else if (req1 && !req0) begin
      winner_c = REQ_DBG;
    end
    ptr_d = ptr_q;
    if (gnt_en) begin
      ptr_d = ~winner_c;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_CPU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter/sequencer sharing a byte-wide big-endian
// data memory between the CPU (requester 0) and debug/loader (requester 1).
// Each 32-bit access is issued as four byte beats at addr..addr+3 (mod 2^AW).
// Optional feature macro: DMEM_ARB_ALIGN_CHECK_EN (unaligned accesses are
// rejected with err instead of being executed).
//   clk, rst_n                 - clock, async active-low reset
//   reqN/weN/addrN/wdataN      - requester N handshake and access fields
//   ackN/rdataN/errN           - one-cycle completion, read word, error flag
//   busy                       - access in progress (XFER or DONE)
//   gnt_id                     - current/last memory owner
//   mem_addr/mem_we/mem_wdata  - byte port to the array (decoded from state)
//   mem_rdata                  - combinational read byte at mem_addr
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AW-1:0]     addr0,
  input  logic [AW-1:0]     addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [WORD_W-1:0] rdata0,
  output logic [WORD_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic              gnt_id,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  req_data_t           rq_q, rq_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                gnt_q, gnt_d;
  logic [WORD_W-1:0]   rbuf_q, rbuf_d;
  logic [WORD_W-1:0]   rdata0_q, rdata0_d;
  logic [WORD_W-1:0]   rdata1_q, rdata1_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                err0_q, err0_d;
  logic                err1_q, err1_d;
  logic                busy_q, busy_d;

  logic                grant_c;
  logic                winner_c;
  logic                rr_ptr;
  req_data_t           win_rq_c;
  logic [AW-1:0]       win_addr_c;

  dmem_arb_rr u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .gnt_en   (grant_c),
    .winner_c (winner_c),
    .ptr      (rr_ptr)
  );

  // Fields of the requester that would win this cycle.
  always_comb begin
    win_rq_c   = '{we: we0, wdata: wdata0};
    win_addr_c = addr0;
    if (winner_c == REQ_DBG) begin
      win_rq_c   = '{we: we1, wdata: wdata1};
      win_addr_c = addr1;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rq_d     = rq_q;
    addr_d   = addr_q;
    gnt_d    = gnt_q;
    rbuf_d   = rbuf_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    busy_d   = 1'b0;
    grant_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_c = 1'b1;
          gnt_d   = winner_c;
          rq_d    = win_rq_c;
          addr_d  = win_addr_c;
          beat_d  = '0;
          state_d = XFER;
          busy_d  = 1'b1;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
          // Unaligned word: no beats, acknowledge with error next cycle.
          if (win_addr_c[1:0] != 2'b00) begin
            state_d = DONE;
            ack0_d  = (winner_c == REQ_CPU);
            ack1_d  = (winner_c == REQ_DBG);
            err0_d  = (winner_c == REQ_CPU);
            err1_d  = (winner_c == REQ_DBG);
          end
`endif
        end
      end

      XFER: begin
        busy_d = 1'b1;
        if (!rq_q.we) begin
          rbuf_d = put_byte(rbuf_q, beat_q, mem_rdata);
        end
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          state_d = DONE;
          ack0_d  = (gnt_q == REQ_CPU);
          ack1_d  = (gnt_q == REQ_DBG);
          // Publish the assembled word only together with the ack.
          if (!rq_q.we) begin
            if (gnt_q == REQ_CPU) begin
              rdata0_d = rbuf_d;
            end else begin
              rdata1_d = rbuf_d;
            end
          end
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      rq_q     <= '0;
      addr_q   <= '0;
      gnt_q    <= REQ_CPU;
      rbuf_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      rq_q     <= rq_d;
      addr_q   <= addr_d;
      gnt_q    <= gnt_d;
      rbuf_q   <= rbuf_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      busy_q   <= busy_d;
    end
  end

  // Memory port, decoded from registered state only.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (state_q == XFER) begin
      mem_addr  = addr_q + AW'(beat_q);
      mem_wdata = word_byte(rq_q.wdata, beat_q);
      mem_we    = rq_q.we;
    end
  end

  // While an access is in flight the pointer always names the other requester.
  a_ptr_tracks_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> (rr_ptr == ~gnt_q));

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = busy_q;
  assign gnt_id = gnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter.
// Expected acks and write beats are queued at issue time from a word-level
// memory model; a monitor pops and compares whenever the DUT acks or strobes.
module tb_dmem_arbiter;

  localparam int unsigned AW = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1, busy, gnt_id, mem_we;
  logic [31:0] rdata0, rdata1;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  dmem_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .busy(busy), .gnt_id(gnt_id),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory array attached to the DUT.
  logic [7:0] mem [64];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Reference model state.
  typedef struct { logic port; logic [31:0] rdata; logic err; } exp_t;
  typedef struct { logic [5:0] addr; logic [7:0] data; } beat_t;
  exp_t        exp_q[$];
  beat_t       bq[$];
  logic [7:0]  ref_mem [64];
  logic [31:0] last_rd [2];
  logic        mptr;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic rejects(input logic [5:0] a);
    logic r;
    r = (a[1:0] != 2'b00);
`ifndef DMEM_ARB_ALIGN_CHECK_EN
    r = 1'b0;
`endif
    return r;
  endfunction

  // Word-level effect of one granted access, in grant order.
  function automatic void model(input logic p, input logic we, input logic [5:0] a,
                                input logic [31:0] wd);
    exp_t  e;
    beat_t bt;
    e.port  = p;
    e.err   = 1'b0;
    e.rdata = last_rd[p];
    if (rejects(a)) begin
      e.err = 1'b1;
    end else if (we) begin
      for (int k = 0; k < 4; k++) begin
        bt.addr = a + 6'(k);
        bt.data = wd[31-8*k -: 8];
        ref_mem[bt.addr] = bt.data;
        bq.push_back(bt);
      end
    end else begin
      for (int k = 0; k < 4; k++) e.rdata[31-8*k -: 8] = ref_mem[a + 6'(k)];
      last_rd[p] = e.rdata;
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: compare whatever the DUT presents against the queues.
  always @(negedge clk) begin : mon
    exp_t  e;
    beat_t b;
    if (rst_n) begin
      if (ack0 || ack1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack actual=%b%b required=none", ack1, ack0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", 32'({ack1, ack0}), e.port ? 32'd2 : 32'd1);
          chk("gnt_id", 32'(gnt_id), 32'(e.port));
          chk("rdata", e.port ? rdata1 : rdata0, e.rdata);
          chk("err", 32'(e.port ? err1 : err0), 32'(e.err));
          chk("busy_at_ack", 32'(busy), 32'd1);
        end
      end
      if (mem_we) begin
        if (bq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_mem_we actual=addr%0d required=none", mem_addr);
        end else begin
          b = bq.pop_front();
          chk("beat_addr", 32'(mem_addr), 32'(b.addr));
          chk("beat_data", 32'(mem_wdata), 32'(b.data));
        end
      end
      if (!busy || ack0 || ack1) chk("idle_mem_port", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},    32'({ack0, ack1}), 32'd0);
    chk({tag, "_err"},    32'({err0, err1}), 32'd0);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
    chk({tag, "_mem"},    32'({mem_we, mem_addr, mem_wdata}), 32'd0);
    chk({tag, "_rdata0"}, rdata0, 32'd0);
    chk({tag, "_rdata1"}, rdata1, 32'd0);
  endtask

  // One round: raise the chosen requests, predict in grant order, wait for acks.
  task automatic round(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic [5:0] a0, input logic [5:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, output int lat);
    logic p0, p1;
    int   n;
    @(negedge clk);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    if (r0 && r1) begin
      if (mptr == 1'b0) begin model(1'b0, w0, a0, d0); model(1'b1, w1, a1, d1); end
      else begin model(1'b1, w1, a1, d1); model(1'b0, w0, a0, d0); end
    end else if (r0) begin
      model(1'b0, w0, a0, d0); mptr = 1'b1;
    end else if (r1) begin
      model(1'b1, w1, a1, d1); mptr = 1'b0;
    end
    p0 = r0; p1 = r1; n = 0; lat = 0;
    while ((p0 || p1) && n < 60) begin
      @(negedge clk);
      n++;
      if (ack0 && p0) begin p0 = 1'b0; req0 = 1'b0; if (lat == 0) lat = n; end
      if (ack1 && p1) begin p1 = 1'b0; req1 = 1'b0; if (lat == 0) lat = n; end
    end
    if (p0 || p1) begin
      checks++; failures++;
      $display("FAIL round_timeout actual=pending%b%b required=done", p1, p0);
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : drive
    logic [7:0]  v;
    logic [7:0]  old42, old43;
    int          lat, r;
    beat_t       bt;
    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end
    for (int i = 0; i < 4; i++) begin
      v = 8'(8'h12 + 8'(i) * 8'h22);
      mem[10 + i] <= v;
      ref_mem[10 + i] = v;
    end
    last_rd[0] = '0; last_rd[1] = '0; mptr = 1'b0;

    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // CPU word read of 12 34 56 78.
    round(1, 0, 0, 0, 6'd10, 6'd0, 32'd0, 32'd0, lat);
    chk("read_latency", 32'(lat), rejects(6'd10) ? 32'd1 : 32'd5);
    // Debug write DEADBEEF at 20.
    round(0, 1, 0, 1, 6'd0, 6'd20, 32'd0, 32'hDEADBEEF, lat);
    chk("write_latency", 32'(lat), 32'd5);
    // Simultaneous reads, then simultaneous writes.
    round(1, 1, 0, 0, 6'd20, 6'd8, 32'd0, 32'd0, lat);
    round(1, 1, 1, 1, 6'd32, 6'd36, 32'h11223344, 32'h55667788, lat);
    round(1, 1, 0, 0, 6'd32, 6'd36, 32'd0, 32'd0, lat);
    // Wrap-around write and read-back.
    round(1, 0, 1, 0, 6'd62, 6'd0, 32'h01020304, 32'd0, lat);
    round(0, 1, 0, 0, 6'd0, 6'd62, 32'd0, 32'd0, lat);
    // Unaligned debug access.
    round(0, 1, 0, 0, 6'd0, 6'd5, 32'd0, 32'd0, lat);
    chk("unaligned_latency", 32'(lat), rejects(6'd5) ? 32'd1 : 32'd5);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 3);
      round(r[0], r[1], 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom),
            $urandom, $urandom, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during beat 2 of an aligned write.
    @(negedge clk);
    old42 = ref_mem[42]; old43 = ref_mem[43];
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd40; wdata0 = 32'hAABBCCDD;
    for (int k = 0; k < 3; k++) begin
      bt.addr = 6'(40 + k);
      bt.data = wdata0[31-8*k -: 8];
      bq.push_back(bt);
    end
    ref_mem[40] = 8'hAA; ref_mem[41] = 8'hBB;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0; req0 = 1'b0;
    #1 chk_reset_outputs("midreset");
    mptr = 1'b0; last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk);
    chk("midreset_byte40", 32'(mem[40]), 32'hAA);
    chk("midreset_byte41", 32'(mem[41]), 32'hBB);
    chk("midreset_byte42", 32'(mem[42]), 32'(old42));
    chk("midreset_byte43", 32'(mem[43]), 32'(old43));
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(1, 3);
      round(r[0], r[1], 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom),
            $urandom, $urandom, lat);
    end

    repeat (3) @(negedge clk);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("beat_queue_drained", 32'(bq.size()), 32'd0);
    r = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) r++;
    chk("final_mem_mismatches", 32'(r), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
